// File: rtl/_32bit_mult_unit.sv
// Iterative shift-add multiplier for MULT/MULTU with the HI/LO register pair.
// One product bit per cycle, sign fix-up applied to the magnitude product at the end.
module _32bit_mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] acc, acc_neg;
  logic [WIDTH:0]     upper_sum;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               neg;
  logic [CNT_W-1:0]   cnt;

  // The most negative operand negates to itself, which is correct read as unsigned 2^(WIDTH-1).
  assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
  assign upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_neg   = -acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = SIGN;
      SIGN:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == SIGN);
    done = (state == DONE);
  end

  // HI/LO are loaded on the edge entering DONE so they already show the product while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_hi) hi <= wdata;
          if (wr_lo) lo <= wdata;
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= {upper_sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        SIGN: begin
          if (neg) acc <= acc_neg;
          {hi, lo} <= neg ? acc_neg : acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb__32bit_mult_unit.sv
// Self-checking bench for _32bit_mult_unit: directed corner cases plus random
// MULT/MULTU operands checked against a plain-arithmetic 64-bit product.
module tb__32bit_mult_unit;

  logic        clk = 1'b0;
  logic        rst, start, is_signed, wr_hi, wr_lo;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  _32bit_mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Starts a multiply and waits for done; cyc counts edges from the accepting edge (-1 on timeout).
  task automatic run_mult(input logic [31:0] x, input logic [31:0] y, input logic s,
                          output int cyc, output int busy_cyc);
    @(negedge clk);
    a = x; b = y; is_signed = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
    cyc = 1;
    busy_cyc = 0;
    forever begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) break;
      if (cyc >= 100) begin cyc = -1; break; end
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    @(negedge clk);
    compared += 4;
    if (hi !== 32'h0)  begin mismatched++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
    if (lo !== 32'h0)  begin mismatched++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    @(negedge clk);
    wr_hi = 1'b1; wdata = 32'h12345678;
    @(posedge clk);
    #1 wr_hi = 1'b0;
    @(negedge clk);
    compared += 2;
    if (hi !== 32'h12345678) begin mismatched++; $display("[TB] FAIL mthi_hi: got %h expected 12345678", hi); end
    if (lo !== 32'h0)        begin mismatched++; $display("[TB] FAIL mthi_lo: got %h expected 0", lo); end
  endtask

  task automatic test_mthi_mtlo_both();
    logic [31:0] w;
    w = $urandom;
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = w;
    @(posedge clk);
    #1 wr_hi = 1'b0; wr_lo = 1'b0; wdata = ~w;
    @(negedge clk);
    compared += 2;
    if (hi !== w) begin mismatched++; $display("[TB] FAIL both_hi: got %h expected %h", hi, w); end
    if (lo !== w) begin mismatched++; $display("[TB] FAIL both_lo: got %h expected %h", lo, w); end
  endtask

  task automatic test_multu_max();
    int cyc, bc;
    run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, cyc, bc);
    compared += 4;
    if (cyc !== 34)          begin mismatched++; $display("[TB] FAIL max_latency: got %0d expected 34", cyc); end
    if (bc !== 33)           begin mismatched++; $display("[TB] FAIL max_busy_cycles: got %0d expected 33", bc); end
    if (hi !== 32'hFFFFFFFE) begin mismatched++; $display("[TB] FAIL max_hi: got %h expected fffffffe", hi); end
    if (lo !== 32'h00000001) begin mismatched++; $display("[TB] FAIL max_lo: got %h expected 00000001", lo); end
    @(negedge clk);
    compared += 2;
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL done_pulse: got %b expected 0", done); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mult_signed();
    int cyc, bc;
    run_mult(32'hFFFFFFFD, 32'h00000007, 1'b1, cyc, bc);
    compared += 2;
    if (hi !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL neg3x7_hi: got %h expected ffffffff", hi); end
    if (lo !== 32'hFFFFFFEB) begin mismatched++; $display("[TB] FAIL neg3x7_lo: got %h expected ffffffeb", lo); end
    run_mult(32'h80000000, 32'h80000000, 1'b1, cyc, bc);
    compared += 2;
    if (hi !== 32'h40000000) begin mismatched++; $display("[TB] FAIL minxmin_hi: got %h expected 40000000", hi); end
    if (lo !== 32'h00000000) begin mismatched++; $display("[TB] FAIL minxmin_lo: got %h expected 0", lo); end
  endtask

  task automatic test_protocol();
    logic [31:0] x, y;
    logic [63:0] exp;
    int cyc;
    x = $urandom; y = $urandom;
    exp = ref_mul(x, y, 1'b0);
    @(negedge clk);
    a = x; b = y; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    forever begin
      @(negedge clk);
      if (done) break;
      if (cyc >= 100) begin cyc = -1; break; end
      start = (cyc == 10);
      if (cyc == 10) begin a = $urandom; b = $urandom; is_signed = 1'b1; end
      wr_lo = (cyc == 12);
      wdata = 32'hDEADBEEF;
      @(posedge clk);
      cyc++;
    end
    start = 1'b0; wr_lo = 1'b0;
    compared += 3;
    if (cyc !== 34)         begin mismatched++; $display("[TB] FAIL proto_latency: got %0d expected 34", cyc); end
    if (hi !== exp[63:32])  begin mismatched++; $display("[TB] FAIL proto_hi: got %h expected %h", hi, exp[63:32]); end
    if (lo !== exp[31:0])   begin mismatched++; $display("[TB] FAIL proto_lo: got %h expected %h", lo, exp[31:0]); end
    @(negedge clk);
    @(negedge clk);
    compared += 1;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL proto_no_queue: got busy %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc, bc;
    logic saw_done;
    @(negedge clk);
    a = 32'd5; b = 32'd6; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k < 15; k++) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    compared += 4;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
    if (hi !== 32'h0)  begin mismatched++; $display("[TB] FAIL midrst_hi: got %h expected 0", hi); end
    if (lo !== 32'h0)  begin mismatched++; $display("[TB] FAIL midrst_lo: got %h expected 0", lo); end
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    compared += 1;
    if (saw_done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_no_done: got %b expected 0", saw_done); end
    run_mult(32'd5, 32'd6, 1'b0, cyc, bc);
    compared += 3;
    if (cyc !== 34)     begin mismatched++; $display("[TB] FAIL rerun_latency: got %0d expected 34", cyc); end
    if (hi !== 32'h0)   begin mismatched++; $display("[TB] FAIL rerun_hi: got %h expected 0", hi); end
    if (lo !== 32'd30)  begin mismatched++; $display("[TB] FAIL rerun_lo: got %h expected 1e", lo); end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    logic [31:0] x, y;
    logic [63:0] exp;
    run_mult(32'h0, 32'hDEADBEEF, 1'b0, cyc, bc);
    compared += 2;
    if (hi !== 32'h0) begin mismatched++; $display("[TB] FAIL zero_hi: got %h expected 0", hi); end
    if (lo !== 32'h0) begin mismatched++; $display("[TB] FAIL zero_lo: got %h expected 0", lo); end
    x = $urandom; y = $urandom;
    exp = ref_mul(x, y, 1'b1);
    run_mult(x, y, 1'b1, cyc, bc);
    compared += 3;
    if (cyc !== 34)        begin mismatched++; $display("[TB] FAIL b2b_latency: got %0d expected 34", cyc); end
    if (hi !== exp[63:32]) begin mismatched++; $display("[TB] FAIL b2b_hi: got %h expected %h", hi, exp[63:32]); end
    if (lo !== exp[31:0])  begin mismatched++; $display("[TB] FAIL b2b_lo: got %h expected %h", lo, exp[31:0]); end
  endtask

  task automatic test_random();
    int cyc, bc;
    logic [31:0] x, y;
    logic        s;
    logic [63:0] exp;
    for (int i = 0; i < 16; i++) begin
      x = $urandom; y = $urandom; s = $urandom_range(0, 1);
      if (i == 0) x = 32'h7FFFFFFF;
      if (i == 1) y = 32'h80000000;
      exp = ref_mul(x, y, s);
      run_mult(x, y, s, cyc, bc);
      compared += 2;
      if (cyc !== 34)
        begin mismatched++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected 34", i, cyc); end
      if ({hi, lo} !== exp)
        begin mismatched++; $display("[TB] FAIL rand_product[%0d] %h*%h s=%b: got %h expected %h", i, x, y, s, {hi, lo}, exp); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    a = '0; b = '0; wdata = '0;
    test_reset();
    test_mthi_mtlo_both();
    test_multu_max();
    test_mult_signed();
    test_protocol();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
